// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch stage, its instruction memory and the decode stage.
// The slave modport is the fetch unit; the master side drives control and memory data.
interface fetch_unit_if #(
  parameter int DATA_LENGTH = 32,
  parameter int ADDR_WIDTH  = 5
);
  logic                   start;
  logic                   stall;
  logic                   branch_taken;
  logic [ADDR_WIDTH-1:0]  branch_target;
  logic                   halt;
  logic [ADDR_WIDTH-1:0]  imem_address;
  logic [DATA_LENGTH-1:0] imem_data;
  logic [DATA_LENGTH-1:0] instr;
  logic [ADDR_WIDTH-1:0]  instr_pc;
  logic                   instr_valid;
  logic                   halted;

  modport master (
    output start, stall, branch_taken, branch_target, halt, imem_data,
    input  imem_address, instr, instr_pc, instr_valid, halted
  );

  modport slave (
    input  start, stall, branch_taken, branch_target, halt, imem_data,
    output imem_address, instr, instr_pc, instr_valid, halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and IDLE/RUN/HALT control.
// The memory address is taken straight from the PC register, so no input reaches it combinationally.
module fetch_unit #(
  parameter int  DATA_LENGTH = 32,
  parameter int  MEM_LENGTH  = 32,
  localparam int ADDR_WIDTH  = $clog2(MEM_LENGTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_unit_if.slave bus
);
  localparam int                  PC_EXT_W    = ADDR_WIDTH + 1;
  localparam logic [PC_EXT_W-1:0] MEM_LEN_EXT = PC_EXT_W'(MEM_LENGTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t                 state_reg;
  logic [ADDR_WIDTH-1:0]  pc_reg;
  logic [ADDR_WIDTH-1:0]  instr_pc_reg;
  logic [DATA_LENGTH-1:0] instr_reg;
  logic                   instr_valid_reg;
  logic                   halted_reg;

  logic [PC_EXT_W-1:0]    pc_inc_ext;
  logic [PC_EXT_W-1:0]    target_ext;
  logic [ADDR_WIDTH-1:0]  pc_seq_next;
  logic [ADDR_WIDTH-1:0]  pc_redirect_next;

  // One extra bit keeps PC+1 exact, so wrap works for non-power-of-2 depths.
  always_comb begin
    pc_inc_ext       = {1'b0, pc_reg} + PC_EXT_W'(1);
    target_ext       = {1'b0, bus.branch_target};
    pc_seq_next      = (pc_inc_ext == MEM_LEN_EXT) ? '0 : pc_inc_ext[ADDR_WIDTH-1:0];
    pc_redirect_next = (target_ext >= MEM_LEN_EXT) ? '0 : bus.branch_target;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      pc_reg          <= '0;
      instr_reg       <= '0;
      instr_pc_reg    <= '0;
      instr_valid_reg <= 1'b0;
      halted_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          instr_valid_reg <= 1'b0;
          if (bus.start) begin
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (bus.halt) begin
            state_reg       <= HALT;
            halted_reg      <= 1'b1;
            instr_valid_reg <= 1'b0;
          end else if (bus.branch_taken) begin
            // Redirect flushes the IF/ID slot; the stale instr/instr_pc stay put.
            pc_reg          <= pc_redirect_next;
            instr_valid_reg <= 1'b0;
          end else if (!bus.stall) begin
            instr_reg       <= bus.imem_data;
            instr_pc_reg    <= pc_reg;
            instr_valid_reg <= 1'b1;
            pc_reg          <= pc_seq_next;
          end
        end
        HALT: begin
          instr_valid_reg <= 1'b0;
          halted_reg      <= 1'b1;
        end
        default: begin
          state_reg       <= IDLE;
          instr_valid_reg <= 1'b0;
          halted_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_address = pc_reg;
  assign bus.instr        = instr_reg;
  assign bus.instr_pc     = instr_pc_reg;
  assign bus.instr_valid  = instr_valid_reg;
  assign bus.halted       = halted_reg;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a 32-deep instance checked against a scoreboard fed by a behavioural model,
// plus a 24-deep instance for non-power-of-2 wrap and out-of-range redirect.
module tb_fetch_unit;
  localparam int AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n32;
  logic rst_n24;

  fetch_unit_if #(.DATA_LENGTH(32), .ADDR_WIDTH(AW)) if32 ();
  fetch_unit_if #(.DATA_LENGTH(32), .ADDR_WIDTH(AW)) if24 ();

  logic [31:0] mem32 [32];
  logic [31:0] mem24 [32];

  assign if32.imem_data = mem32[if32.imem_address];
  assign if24.imem_data = mem24[if24.imem_address];

  fetch_unit #(.DATA_LENGTH(32), .MEM_LENGTH(32)) dut32 (
    .clk   (clk),
    .rst_n (rst_n32),
    .bus   (if32)
  );

  fetch_unit #(.DATA_LENGTH(32), .MEM_LENGTH(24)) dut24 (
    .clk   (clk),
    .rst_n (rst_n24),
    .bus   (if24)
  );

  typedef struct {
    logic [31:0]   instr;
    logic [AW-1:0] pc;
    logic [AW-1:0] ipc;
    logic          valid;
    logic          halted;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model of the 32-deep instance: 0=IDLE 1=RUN 2=HALT
  int          m_state = 0;
  int          m_pc    = 0;
  int          m_ipc   = 0;
  logic [31:0] m_instr = '0;
  logic        m_valid = 1'b0;
  logic        m_halted = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set32(input logic r, input logic s, input logic st,
                       input logic br, input logic [AW-1:0] tgt, input logic h);
    rst_n32            = r;
    if32.start         = s;
    if32.stall         = st;
    if32.branch_taken  = br;
    if32.branch_target = tgt;
    if32.halt          = h;
  endtask

  task automatic model_push();
    exp_t e;
    if (!rst_n32) begin
      m_state = 0; m_pc = 0; m_ipc = 0; m_instr = '0; m_valid = 1'b0; m_halted = 1'b0;
    end else if (m_state == 0) begin
      m_valid = 1'b0;
      if (if32.start) m_state = 1;
    end else if (m_state == 1) begin
      if (if32.halt) begin
        m_state = 2; m_halted = 1'b1; m_valid = 1'b0;
      end else if (if32.branch_taken) begin
        m_pc    = (int'(if32.branch_target) < 32) ? int'(if32.branch_target) : 0;
        m_valid = 1'b0;
      end else if (!if32.stall) begin
        m_instr = mem32[m_pc];
        m_ipc   = m_pc;
        m_valid = 1'b1;
        m_pc    = (m_pc + 1) % 32;
      end
    end else begin
      m_valid = 1'b0;
    end
    e.instr  = m_instr;
    e.pc     = AW'(m_pc);
    e.ipc    = AW'(m_ipc);
    e.valid  = m_valid;
    e.halted = m_halted;
    sb_q.push_back(e);
  endtask

  // One clock of the 32-deep instance: push expectation, clock, pop and compare.
  task automatic step32();
    exp_t e;
    model_push();
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_empty got 0 expected 1");
    end else begin
      e = sb_q.pop_front();
      check("imem_address", 32'(if32.imem_address), 32'(e.pc));
      check("instr",        if32.instr,             e.instr);
      check("instr_pc",     32'(if32.instr_pc),     32'(e.ipc));
      check("instr_valid",  32'(if32.instr_valid),  32'(e.valid));
      check("halted",       32'(if32.halted),       32'(e.halted));
      $display("step t=%0t addr=%0d instr=%08h ipc=%0d valid=%0b halted=%0b",
               $time, if32.imem_address, if32.instr, if32.instr_pc, if32.instr_valid, if32.halted);
    end
  endtask

  task automatic tick24();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp24;
    for (int i = 0; i < 32; i++) begin
      mem32[i] = $urandom();
      mem24[i] = $urandom();
    end
    set32(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    rst_n24            = 1'b0;
    if24.start         = 1'b0;
    if24.stall         = 1'b0;
    if24.branch_taken  = 1'b0;
    if24.branch_target = '0;
    if24.halt          = 1'b0;

    // Reset and start-up
    step32();
    step32();
    check("rst_valid", 32'(if32.instr_valid), 32'd0);
    check("rst_addr",  32'(if32.imem_address), 32'd0);
    set32(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    step32();
    check("start_bubble", 32'(if32.instr_valid), 32'd0);
    set32(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step32();
    check("first_instr", if32.instr, mem32[0]);
    check("first_pc",    32'(if32.instr_pc), 32'd0);
    step32();
    step32();
    check("third_pc", 32'(if32.instr_pc), 32'd2);
    step32();
    step32();
    check("pre_stall_addr", 32'(if32.imem_address), 32'd5);

    // Stall three cycles at PC=5
    set32(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step32();
      check("stall_addr",  32'(if32.imem_address), 32'd5);
      check("stall_ipc",   32'(if32.instr_pc), 32'd4);
      check("stall_valid", 32'(if32.instr_valid), 32'd1);
    end
    set32(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step32();
    check("post_stall_ipc", 32'(if32.instr_pc), 32'd5);
    step32();
    check("pre_branch_addr", 32'(if32.imem_address), 32'd7);

    // Branch with stall also asserted: branch wins
    set32(1'b1, 1'b0, 1'b1, 1'b1, AW'(20), 1'b0);
    step32();
    check("branch_bubble", 32'(if32.instr_valid), 32'd0);
    check("branch_addr",   32'(if32.imem_address), 32'd20);
    set32(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step32();
    check("branch_ipc",   32'(if32.instr_pc), 32'd20);
    check("branch_instr", if32.instr, mem32[20]);

    // Wrap 31 -> 0 with continuous valid
    for (int i = 0; i < 13; i++) begin
      step32();
      if (i == 10) check("wrap_ipc31", 32'(if32.instr_pc), 32'd31);
      if (i == 11) begin
        check("wrap_ipc0",   32'(if32.instr_pc), 32'd0);
        check("wrap_valid",  32'(if32.instr_valid), 32'd1);
      end
    end

    // Halt at PC=10, then try to disturb it
    set32(1'b1, 1'b0, 1'b0, 1'b1, AW'(10), 1'b0);
    step32();
    set32(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    step32();
    check("halt_flag",  32'(if32.halted), 32'd1);
    check("halt_valid", 32'(if32.instr_valid), 32'd0);
    check("halt_addr",  32'(if32.imem_address), 32'd10);
    set32(1'b1, 1'b1, 1'b1, 1'b1, AW'(3), 1'b0);
    for (int i = 0; i < 3; i++) step32();
    check("halt_hold_addr", 32'(if32.imem_address), 32'd10);
    check("halt_hold_flag", 32'(if32.halted), 32'd1);

    // Reset mid-run at PC=12 with a live instruction
    set32(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step32();
    set32(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    step32();
    set32(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 12; i++) step32();
    check("mid_addr",  32'(if32.imem_address), 32'd12);
    check("mid_valid", 32'(if32.instr_valid), 32'd1);
    set32(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step32();
    check("mid_rst_valid", 32'(if32.instr_valid), 32'd0);
    check("mid_rst_addr",  32'(if32.imem_address), 32'd0);
    check("mid_rst_instr", if32.instr, 32'd0);
    check("mid_rst_ipc",   32'(if32.instr_pc), 32'd0);
    set32(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    step32();
    set32(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step32();
    check("resume_ipc",   32'(if32.instr_pc), 32'd0);
    check("resume_instr", if32.instr, mem32[0]);

    // Random stall/branch traffic
    for (int i = 0; i < 300; i++) begin
      set32(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 7) == 0), AW'($urandom_range(0, 31)), 1'b0);
      step32();
    end
    set32(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    step32();
    set32(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    step32();

    // 24-deep instance: wrap 23 -> 0 and out-of-range redirect
    tick24();
    tick24();
    check("w24_rst_valid", 32'(if24.instr_valid), 32'd0);
    rst_n24    = 1'b1;
    if24.start = 1'b1;
    tick24();
    if24.start = 1'b0;
    exp24 = 0;
    for (int i = 0; i < 30; i++) begin
      tick24();
      check("w24_ipc",   32'(if24.instr_pc), 32'(exp24));
      check("w24_instr", if24.instr, mem24[exp24]);
      check("w24_valid", 32'(if24.instr_valid), 32'd1);
      $display("w24 t=%0t ipc=%0d instr=%08h", $time, if24.instr_pc, if24.instr);
      exp24 = (exp24 + 1) % 24;
    end
    if24.branch_taken  = 1'b1;
    if24.branch_target = AW'(30);
    tick24();
    check("w24_oor_addr",  32'(if24.imem_address), 32'd0);
    check("w24_oor_valid", 32'(if24.instr_valid), 32'd0);
    if24.branch_taken  = 1'b0;
    if24.branch_target = AW'(23);
    tick24();
    check("w24_oor_ipc", 32'(if24.instr_pc), 32'd0);
    if24.branch_taken = 1'b1;
    tick24();
    check("w24_last_addr", 32'(if24.imem_address), 32'd23);
    if24.branch_taken = 1'b0;
    tick24();
    check("w24_last_ipc",  32'(if24.instr_pc), 32'd23);
    check("w24_wrap_addr", 32'(if24.imem_address), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
